// File: rtl/go_link_pkg.sv
// ---------------------------------------------------------------------------
// go_link_pkg
// Shared definitions for the inter-board move link.
//   MOVE_PASS     : move code meaning "pass"
//   BOARD_MAX     : largest legal row/column index
//   move_t        : move byte split into row/col nibbles
//   frame_state_t : two-byte frame state, shared with the transmitter
//   byte_state_t  : UART byte receiver state
//   move_frame_ok : full validity check of a (move, complement) byte pair
// ---------------------------------------------------------------------------
package go_link_pkg;

  localparam logic [7:0] MOVE_PASS = 8'hFF;
  localparam logic [3:0] BOARD_MAX = 4'd8;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } move_t;

  typedef enum logic {
    FRM_WAIT_B0,
    FRM_WAIT_B1
  } frame_state_t;

  typedef enum logic [1:0] {
    BRX_IDLE,
    BRX_START,
    BRX_DATA,
    BRX_STOP
  } byte_state_t;

  // A frame is good when byte1 is the exact complement of byte0 and byte0
  // is either the pass code or a square inside the board.
  function automatic logic move_frame_ok(input logic [7:0] b0, input logic [7:0] b1);
    move_t m;
    m = move_t'(b0);
    return (b1 == ~b0) &&
           ((b0 == MOVE_PASS) || ((m.row <= BOARD_MAX) && (m.col <= BOARD_MAX)));
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART byte receiver with 2-FF input synchronizer and oversampling.
//   clk_in    : system clock
//   rst_in_n  : asynchronous active-low reset
//   rx        : serial line, idle high, asynchronous to clk_in
//   byte_data : last assembled byte (valid while byte_done is high)
//   byte_done : one-cycle pulse, byte received with a good stop bit
//   byte_err  : one-cycle pulse, stop bit sampled low
//   busy      : receiver is not IDLE (a byte is in progress)
// ---------------------------------------------------------------------------
module uart_byte_rx
  import go_link_pkg::*;
#(
  parameter int CLK_PER_SAMP = 423,
  parameter int SAMP_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       byte_err,
  output logic       busy
);

  localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam int IW = $clog2(SAMP_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_SAMP - 1);
  localparam logic [IW-1:0] S_EARLY  = IW'(SAMP_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] S_MID    = IW'(SAMP_PER_BIT / 2);
  localparam logic [IW-1:0] S_LATE   = IW'(SAMP_PER_BIT / 2 + 1);

  logic [1:0]    r_sync;
  logic          r_rx_prev;
  byte_state_t   r_state;
  byte_state_t   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_s_early;
  logic          r_s_mid;
  logic [7:0]    r_shift;
  logic [3:0]    r_bit_cnt;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_maj;
  logic w_shift_en;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx;
  assign w_tick = (r_state != BRX_IDLE) && (r_cnt == CNT_LAST);
  assign w_maj  = (r_s_early & r_s_mid) | (r_s_early & w_rx) | (r_s_mid & w_rx);

  assign byte_data = r_shift;
  assign busy      = (r_state != BRX_IDLE);

  always_comb begin
    w_state_next = r_state;
    byte_done    = 1'b0;
    byte_err     = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      BRX_IDLE: begin
        if (w_fall) w_state_next = BRX_START;
      end
      BRX_START: begin
        if (w_tick && (r_idx == S_MID)) w_state_next = w_rx ? BRX_IDLE : BRX_DATA;
      end
      BRX_DATA: begin
        // DATA is entered mid start bit, so the first majority taken here is
        // the start bit itself. Nine shifts push it out of the 8-bit register,
        // leaving data bit 0 in [0].
        if (w_tick && (r_idx == S_LATE)) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 4'd8) w_state_next = BRX_STOP;
        end
      end
      BRX_STOP: begin
        if (w_tick && (r_idx == S_LATE)) begin
          w_state_next = BRX_IDLE;
          if (w_maj) byte_done = 1'b1;
          else       byte_err  = 1'b1;
        end
      end
      default: w_state_next = BRX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
      r_state   <= BRX_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_s_early <= 1'b1;
      r_s_mid   <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= w_rx;
      r_state   <= w_state_next;

      if (r_state == BRX_IDLE) begin
        // Counters sit at zero while idle, so a start edge always begins a
        // fresh sample period.
        r_cnt     <= '0;
        r_idx     <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_tick) begin
          r_cnt <= '0;
          r_idx <= r_idx + IW'(1);
          if (r_idx == S_EARLY) r_s_early <= w_rx;
          if (r_idx == S_MID)   r_s_mid   <= w_rx;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_shift_en) begin
          r_shift   <= {w_maj, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/move_link_rx.sv
// ---------------------------------------------------------------------------
// move_link_rx
// Receive end of the inter-board move link: two-byte frames (move, ~move)
// are validated and each good move is strobed out for one cycle.
//   clk_in     : system clock
//   rst_in_n   : asynchronous active-low reset
//   rx         : serial line from the opposing board
//   move_out   : last accepted move ([7:4] row, [3:0] col, 8'hFF = pass)
//   move_valid : one-cycle strobe per accepted frame
//   frame_err  : one-cycle strobe per rejected frame
//   err_count  : rejected-frame count, saturating at 8'hFF
// CLK_PER_SAMP = 0 derives the sample period from CLK_HZ/BAUD_RATE.
// ---------------------------------------------------------------------------
module move_link_rx
  import go_link_pkg::*;
#(
  parameter int CLK_HZ        = 65_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int SAMP_PER_BIT  = 16,
  parameter int CLK_PER_SAMP  = 423,
  parameter int FRAME_TIMEOUT = 65_000
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rx,
  output logic [7:0] move_out,
  output logic       move_valid,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int CPS = (CLK_PER_SAMP > 0) ? CLK_PER_SAMP
                                          : (CLK_HZ / BAUD_RATE / SAMP_PER_BIT);
  localparam int TW  = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(FRAME_TIMEOUT - 1);

  logic [7:0] w_byte_data;
  logic       w_byte_done;
  logic       w_byte_err;
  logic       w_busy;

  frame_state_t r_state;
  frame_state_t w_state_next;
  logic [7:0]   r_b0;
  logic [7:0]   r_move;
  logic         r_valid;
  logic         r_ferr;
  logic [7:0]   r_err_cnt;
  logic [TW-1:0] r_to_cnt;
  logic         w_accept;
  logic         w_reject;

  uart_byte_rx #(
    .CLK_PER_SAMP (CPS),
    .SAMP_PER_BIT (SAMP_PER_BIT)
  ) u_byte_rx (
    .clk_in    (clk_in),
    .rst_in_n  (rst_in_n),
    .rx        (rx),
    .byte_data (w_byte_data),
    .byte_done (w_byte_done),
    .byte_err  (w_byte_err),
    .busy      (w_busy)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      FRM_WAIT_B0: begin
        if (w_byte_err)       w_reject     = 1'b1;
        else if (w_byte_done) w_state_next = FRM_WAIT_B1;
      end
      FRM_WAIT_B1: begin
        if (w_byte_err) begin
          w_reject     = 1'b1;
          w_state_next = FRM_WAIT_B0;
        end else if (w_byte_done) begin
          w_state_next = FRM_WAIT_B0;
          if (move_frame_ok(r_b0, w_byte_data)) w_accept = 1'b1;
          else                                  w_reject = 1'b1;
        end else if (!w_busy && (r_to_cnt == TO_LAST)) begin
          // Evaluated even when a start edge lands this cycle: the timeout
          // wins and that byte is then taken as a new byte0.
          w_reject     = 1'b1;
          w_state_next = FRM_WAIT_B0;
        end
      end
      default: w_state_next = FRM_WAIT_B0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state   <= FRM_WAIT_B0;
      r_b0      <= '0;
      r_move    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_err_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_accept;
      r_ferr  <= w_reject;
      if ((r_state == FRM_WAIT_B0) && w_byte_done) r_b0 <= w_byte_data;
      if (w_accept) r_move <= r_b0;
      if (w_reject && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      // Only line-idle time between the bytes counts toward the timeout.
      if (r_state != FRM_WAIT_B1) r_to_cnt <= '0;
      else if (!w_busy)           r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign move_out   = r_move;
  assign move_valid = r_valid;
  assign frame_err  = r_ferr;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_move_link_rx.sv
// ---------------------------------------------------------------------------
// tb_move_link_rx
// Directed bench for move_link_rx with a scaled bit period (16 clk/bit) and
// a 1000-clock frame timeout so the whole run stays short.
// ---------------------------------------------------------------------------
module tb_move_link_rx;

  localparam int BIT = 16;
  localparam int TO  = 1000;

  logic       clk_in;
  logic       rst_in_n;
  logic       rx;
  logic [7:0] move_out;
  logic       move_valid;
  logic       frame_err;
  logic [7:0] err_count;

  int n_tests;
  int n_fail;
  int n_valid;
  int n_ferr;
  int v0;
  int f0;
  logic prev_v;
  logic prev_f;

  move_link_rx #(
    .CLK_HZ        (65_000_000),
    .BAUD_RATE     (9600),
    .SAMP_PER_BIT  (16),
    .CLK_PER_SAMP  (1),
    .FRAME_TIMEOUT (TO)
  ) dut (
    .clk_in     (clk_in),
    .rst_in_n   (rst_in_n),
    .rx         (rx),
    .move_out   (move_out),
    .move_valid (move_valid),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Strobe monitor: counts pulses and checks exclusivity / single-cycle width.
  always @(negedge clk_in) begin
    if (!rst_in_n) begin
      prev_v = 1'b0;
      prev_f = 1'b0;
    end else begin
      if (move_valid || frame_err) begin
        n_tests++;
        assert (!(move_valid && frame_err) && !(move_valid && prev_v) && !(frame_err && prev_f))
        else begin
          n_fail++;
          $error("FAIL strobe_shape: observed valid=%0b err=%0b prev_valid=%0b prev_err=%0b required exclusive single-cycle",
                 move_valid, frame_err, prev_v, prev_f);
        end
      end
      if (move_valid) n_valid++;
      if (frame_err)  n_ferr++;
      prev_v = move_valid;
      prev_f = frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
    v0 = n_valid;
    f0 = n_ferr;
    send_byte(b0, 1'b1);
    idle(4);
    send_byte(b1, 1'b1);
    idle(20);
    @(negedge clk_in);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_valid  = 0;
    n_ferr   = 0;
    prev_v   = 1'b0;
    prev_f   = 1'b0;
    rx       = 1'b1;
    rst_in_n = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_move_out",  {24'd0, move_out}, 32'h00);
    check("rst_valid",     {31'd0, move_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'h00);
    @(posedge clk_in); #1;
    rst_in_n = 1'b1;
    idle(10);

    // Good move 0x34 / 0xCB
    send_frame(8'h34, 8'hCB);
    check("f1_move",  {24'd0, move_out}, 32'h34);
    check("f1_valid", n_valid - v0, 1);
    check("f1_ferr",  n_ferr - f0, 0);
    check("f1_errc",  {24'd0, err_count}, 32'd0);

    // Pass move 0xFF / 0x00
    send_frame(8'hFF, 8'h00);
    check("pass_move",  {24'd0, move_out}, 32'hFF);
    check("pass_valid", n_valid - v0, 1);

    // Complement mismatch
    send_frame(8'h34, 8'hCA);
    check("cmp_ferr",  n_ferr - f0, 1);
    check("cmp_valid", n_valid - v0, 0);
    check("cmp_errc",  {24'd0, err_count}, 32'd1);
    check("cmp_hold",  {24'd0, move_out}, 32'hFF);

    // Row 9 out of range
    send_frame(8'h9A, 8'h65);
    check("row9_ferr",  n_ferr - f0, 1);
    check("row9_valid", n_valid - v0, 0);
    check("row9_errc",  {24'd0, err_count}, 32'd2);

    // Byte0 with stop bit low
    f0 = n_ferr;
    send_byte(8'h5A, 1'b0);
    idle(20);
    @(negedge clk_in);
    check("stop_ferr", n_ferr - f0, 1);
    check("stop_errc", {24'd0, err_count}, 32'd3);

    // Byte0 then silence: timeout
    f0 = n_ferr;
    send_byte(8'h21, 1'b1);
    idle(TO - 50);
    @(negedge clk_in);
    check("to_early", n_ferr - f0, 0);
    idle(100);
    @(negedge clk_in);
    check("to_ferr", n_ferr - f0, 1);
    check("to_errc", {24'd0, err_count}, 32'd4);
    send_frame(8'h21, 8'hDE);
    check("to_next_move",  {24'd0, move_out}, 32'h21);
    check("to_next_valid", n_valid - v0, 1);

    // Short low glitch on an idle line
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    idle(40);
    @(negedge clk_in);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr",  n_ferr - f0, 0);

    // Boundary square row 8 col 8 accepted right after the glitch
    send_frame(8'h88, 8'h77);
    check("b88_move",  {24'd0, move_out}, 32'h88);
    check("b88_valid", n_valid - v0, 1);
    check("b88_ferr",  n_ferr - f0, 0);

    // Column 9 rejected
    send_frame(8'h89, 8'h76);
    check("col9_ferr", n_ferr - f0, 1);
    check("col9_errc", {24'd0, err_count}, 32'd5);
    check("col9_hold", {24'd0, move_out}, 32'h88);

    // Reset in the middle of byte1 data
    v0 = n_valid;
    f0 = n_ferr;
    send_byte(8'h34, 1'b1);
    idle(4);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_in_n = 1'b0;
    rx       = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("mid_rst_move", {24'd0, move_out}, 32'h00);
    check("mid_rst_errc", {24'd0, err_count}, 32'h00);
    check("mid_rst_valid", {31'd0, move_valid}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    @(posedge clk_in); #1;
    rst_in_n = 1'b1;
    idle(TO + 200);
    @(negedge clk_in);
    check("post_rst_valid", n_valid - v0, 0);
    check("post_rst_ferr",  n_ferr - f0, 0);

    // Saturation of the error counter
    f0 = n_ferr;
    for (int i = 0; i < 254; i++) begin
      send_byte(8'h5A, 1'b0);
      idle(8);
    end
    idle(10);
    @(negedge clk_in);
    check("sat_254", {24'd0, err_count}, 32'hFE);
    send_byte(8'h5A, 1'b0);
    idle(18);
    @(negedge clk_in);
    check("sat_255", {24'd0, err_count}, 32'hFF);
    check("sat_255_ferr", n_ferr - f0, 255);
    send_byte(8'h5A, 1'b0);
    idle(18);
    @(negedge clk_in);
    check("sat_256", {24'd0, err_count}, 32'hFF);
    check("sat_256_ferr", n_ferr - f0, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
